pwm_update_scheduler: RTL and testbench

- Owns the duty/phase tables that drive pwm_preconditioner and the pwm_gen array.
- Host writes go into a shadow bank at any time.
- A commit copies the whole shadow bank into the active tables atomically, and only on an ultrasound period boundary (START). pwm_gen therefore never sees a mid-period mix of old and new settings.
- Sits between the host/register interface and pwm_preconditioner, in the CLK_PWM domain.

---
 rtl/pwm_update_scheduler.sv | 148 ++++++++++++++
 tb/tb_pwm_update_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_scheduler.sv
// rtl/pwm_update_scheduler.sv - shadow/active duty-phase tables with period-aligned atomic commit
// Optional feature macro: PWM_UPDATE_AUTO_COMMIT_EN (commit at START whenever the shadow bank is dirty)
module pwm_update_scheduler #(
   parameter int WIDTH  = 13,
   parameter int DEPTH  = 249,
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [WIDTH-1:0]  WR_DUTY,
   input  logic [WIDTH-1:0]  WR_PHASE,
   output logic              WR_ERR,
   input  logic              COMMIT_REQ,
   output logic              PENDING,
   output logic              UPDATED,
   output logic [WIDTH-1:0]  DUTY  [0:DEPTH-1],
   output logic [WIDTH-1:0]  PHASE [0:DEPTH-1]
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   // One extra bit so DEPTH == 2**ADDR_W would still compare correctly.
   localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             ready_q;
   logic             wr_fire;
   logic             in_range;
   logic             auto_go;
   logic [WIDTH-1:0] shadow_duty  [0:DEPTH-1];
   logic [WIDTH-1:0] shadow_phase [0:DEPTH-1];

   assign in_range = ({1'b0, WR_ADDR} < DEPTH_LIM);
   // The copy cycle owns the shadow bank, so the host is stalled only then.
   assign WR_READY = ready_q && (state != ST_COMMIT);
   assign wr_fire  = WR_VALID && WR_READY;

`ifdef PWM_UPDATE_AUTO_COMMIT_EN
   logic dirty;

   // Track whether the shadow bank holds anything the active tables lack.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dirty <= 1'b0;
      end else if (state == ST_COMMIT) begin
         dirty <= 1'b0;
      end else if (wr_fire && in_range) begin
         dirty <= 1'b1;
      end
   end

   assign auto_go = dirty;
   assign PENDING = (state == ST_ARMED) || dirty;
`else
   assign auto_go = 1'b0;
   assign PENDING = (state == ST_ARMED);
`endif

   // Write port becomes ready on the first clock after reset release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   // Next-state selection: arm on request, commit only on a period boundary.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (START && auto_go) begin
               state_nxt = ST_COMMIT;
            end else if (COMMIT_REQ) begin
               state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (START) begin
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_nxt = COMMIT_REQ ? ST_ARMED : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Shadow bank: host writes land here at any time; out-of-range writes are dropped.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow_duty[i]  <= '0;
            shadow_phase[i] <= '0;
         end
      end else if (wr_fire && in_range) begin
         shadow_duty[WR_ADDR]  <= WR_DUTY;
         shadow_phase[WR_ADDR] <= WR_PHASE;
      end
   end

   // Active tables: whole-bank copy in the single COMMIT cycle only.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            DUTY[i]  <= '0;
            PHASE[i] <= '0;
         end
      end else if (state == ST_COMMIT) begin
         for (int i = 0; i < DEPTH; i++) begin
            DUTY[i]  <= shadow_duty[i];
            PHASE[i] <= shadow_phase[i];
         end
      end
   end

   // Status pulses: error for a dropped write, update notice after the copy.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         WR_ERR  <= 1'b0;
         UPDATED <= 1'b0;
      end else begin
         WR_ERR  <= wr_fire && !in_range;
         UPDATED <= (state == ST_COMMIT);
      end
   end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// tb/tb_pwm_update_scheduler.sv - directed self-checking bench for pwm_update_scheduler
module tb_pwm_update_scheduler;

   localparam int WIDTH  = 13;
   localparam int DEPTH  = 249;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_duty;
   logic [WIDTH-1:0]  wr_phase;
   logic              wr_err;
   logic              commit_req;
   logic              pending;
   logic              updated;
   logic [WIDTH-1:0]  duty  [0:DEPTH-1];
   logic [WIDTH-1:0]  phase [0:DEPTH-1];

   pwm_update_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start),
      .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr),
      .WR_DUTY(wr_duty), .WR_PHASE(wr_phase), .WR_ERR(wr_err),
      .COMMIT_REQ(commit_req), .PENDING(pending), .UPDATED(updated),
      .DUTY(duty), .PHASE(phase)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int upd_seen = 0;

   // Reference model of shadow and active tables
   logic [WIDTH-1:0] m_sd [0:DEPTH-1];
   logic [WIDTH-1:0] m_sp [0:DEPTH-1];
   logic [WIDTH-1:0] m_ad [0:DEPTH-1];
   logic [WIDTH-1:0] m_ap [0:DEPTH-1];

   typedef struct {
      int   addr;
      int   d;
      int   p;
      logic req;
      logic exp_err;
      logic exp_pend;
   } wvec_t;

   wvec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         if (updated === 1'b1) upd_seen++;
      end
   endtask

   task automatic check_tables(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (duty[i] !== m_ad[i] || phase[i] !== m_ap[i]) bad++;
      end
      chk({name, " table_mismatches"}, bad, 0);
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_sd[i] = '0; m_sp[i] = '0; m_ad[i] = '0; m_ap[i] = '0;
      end
   endtask

   task automatic model_commit();
      for (int i = 0; i < DEPTH; i++) begin
         m_ad[i] = m_sd[i];
         m_ap[i] = m_sp[i];
      end
   endtask

   task automatic do_write(input int addr, input int d, input int p, input logic req);
      wr_valid   = 1'b1;
      wr_addr    = addr[ADDR_W-1:0];
      wr_duty    = d[WIDTH-1:0];
      wr_phase   = p[WIDTH-1:0];
      commit_req = req;
      if (addr < DEPTH) begin
         m_sd[addr] = d[WIDTH-1:0];
         m_sp[addr] = p[WIDTH-1:0];
      end
      step();
      wr_valid   = 1'b0;
      commit_req = 1'b0;
   endtask

   // One START period with no commit expected
   task automatic start_period();
      start = 1'b1;
      run_cycles(1);
      start = 1'b0;
      run_cycles(3);
   endtask

   // START seen while armed: T+1 copy cycle, T+2 new values and UPDATED
   task automatic commit_seq(input string name);
      start = 1'b1;
      step();
      start    = 1'b0;
      wr_valid = 1'b0;
      chk({name, " ready_low_T1"}, wr_ready, 0);
      chk({name, " updated_T1"}, updated, 0);
      check_tables({name, " old_T1"});
      step();
      model_commit();
      chk({name, " updated_T2"}, updated, 1);
      chk({name, " pending_T2"}, pending, 0);
      chk({name, " ready_T2"}, wr_ready, 1);
      check_tables({name, " new_T2"});
      step();
      chk({name, " updated_T3"}, updated, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; commit_req = 1'b0;
      wr_addr = '0; wr_duty = '0; wr_phase = '0;
      model_clear();

      vecs[0] = '{0,   2500, 1000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{248, 1,    0,    1'b1, 1'b0, 1'b1};
      vecs[2] = '{249, 7,    7,    1'b0, 1'b1, 1'b1};
      vecs[3] = '{255, 5,    5,    1'b0, 1'b1, 1'b1};
      vecs[4] = '{100, 8191, 8191, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{0,   2500, 4000, 1'b0, 1'b0, 1'b1};

      // 1: reset state
      run_cycles(3);
      chk("rst pending", pending, 0);
      chk("rst updated", updated, 0);
      chk("rst wr_err", wr_err, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst wr_ready", wr_ready, 1);
      check_tables("post_rst");
      upd_seen = 0;
      for (int n = 0; n < 5; n++) start_period();
      chk("idle_periods updated_count", upd_seen, 0);
      chk("idle_periods pending", pending, 0);

`ifdef PWM_UPDATE_AUTO_COMMIT_EN
      // 6: dirty shadow commits on the next START without a request
      do_write(1, 2, 1, 1'b0);
      chk("auto pending_dirty", pending, 1);
      run_cycles(2);
      commit_seq("auto");
      chk("auto duty1", duty[1], 2);
      chk("auto phase1", phase[1], 1);
      upd_seen = 0;
      for (int n = 0; n < 3; n++) start_period();
      chk("auto no_more_updates", upd_seen, 0);
      chk("auto pending_clear", pending, 0);
`else
      // 2: writes stay in shadow until a requested commit
      do_write(0, 2500, 2500, 1'b0);
      upd_seen = 0;
      for (int n = 0; n < 3; n++) start_period();
      chk("t2 no_commit updated_count", upd_seen, 0);
      check_tables("t2 no_commit");
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
      chk("t2 pending", pending, 1);
      run_cycles(2);
      commit_seq("t2");
      chk("t2 duty0", duty[0], 2500);
      chk("t2 phase0", phase[0], 2500);

      // 3/4: table of writes, including out-of-range and writes while armed
      for (int v = 0; v < 6; v++) begin
         do_write(vecs[v].addr, vecs[v].d, vecs[v].p, vecs[v].req);
         chk($sformatf("vec%0d wr_err", v), wr_err, vecs[v].exp_err);
         chk($sformatf("vec%0d pending", v), pending, vecs[v].exp_pend);
      end
      step();
      chk("vec wr_err_clears", wr_err, 0);
      commit_seq("t3");
      chk("t3 duty0", duty[0], 2500);
      chk("t3 phase0", phase[0], 4000);
      chk("t3 duty248", duty[248], 1);
      chk("t3 phase248", phase[248], 0);
      chk("t3 duty100", duty[100], 8191);
      chk("t3 duty1", duty[1], 0);

      // 4: COMMIT_REQ together with START in IDLE only arms
      do_write(6, 3, 3, 1'b0);
      commit_req = 1'b1;
      start      = 1'b1;
      step();
      commit_req = 1'b0;
      start      = 1'b0;
      chk("t4 req_with_start pending", pending, 1);
      upd_seen = 0;
      run_cycles(3);
      chk("t4 no_immediate_commit", upd_seen, 0);
      check_tables("t4 still_old");
      // write in the same cycle the armed state sees START is included
      wr_valid = 1'b1; wr_addr = 8'd5; wr_duty = 13'd9; wr_phase = 13'd9;
      m_sd[5] = 13'd9; m_sp[5] = 13'd9;
      commit_seq("t4");
      chk("t4 duty5", duty[5], 9);
      chk("t4 duty6", duty[6], 3);

      // 5: write held across the commit cycle; COMMIT_REQ during COMMIT re-arms
      do_write(8, 11, 12, 1'b1);
      chk("t5 pending", pending, 1);
      start = 1'b1;
      step();
      start      = 1'b0;
      wr_valid   = 1'b1; wr_addr = 8'd7; wr_duty = 13'd77; wr_phase = 13'd33;
      commit_req = 1'b1;
      chk("t5 ready_low_commit", wr_ready, 0);
      step();
      commit_req = 1'b0;
      model_commit();
      chk("t5 updated_T2", updated, 1);
      chk("t5 rearmed", pending, 1);
      chk("t5 ready_back", wr_ready, 1);
      check_tables("t5 T2");
      m_sd[7] = 13'd77; m_sp[7] = 13'd33;
      step();
      wr_valid = 1'b0;
      chk("t5 duty7_not_active", duty[7], 0);
      chk("t5 updated_T3", updated, 0);
      commit_seq("t5_rearm");
      chk("t5 duty7_after", duty[7], 77);
      chk("t5 phase7_after", phase[7], 33);

      // 5: asynchronous reset while armed
      do_write(9, 5, 5, 1'b1);
      chk("t5r pending", pending, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("t5r pending_cleared", pending, 0);
      chk("t5r updated", updated, 0);
      check_tables("t5r async_clear");
      run_cycles(2);
      rst_n = 1'b1;
      step();
      chk("t5r wr_ready", wr_ready, 1);
      upd_seen = 0;
      for (int n = 0; n < 2; n++) start_period();
      chk("t5r no_update", upd_seen, 0);
      chk("t5r pending_after", pending, 0);
      check_tables("t5r after_periods");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
